s2p_frame_ctrl: RTL and testbench
=================================

// Module: s2p_frame_ctrl
// PURPOSE
//   Receive-side sequencer for the serial-to-parallel path.
//   Finds a start bit on si, steps the shifter through WIDTH data bits (LSB first),
//   checks an optional parity bit and the stop bit, then hands the word to a 1-entry
//   output holding register.
//   Sits between the serial line / bit-rate strobe and the parallel consumer.
//   Frame on the line: idle 1, start 0, WIDTH data bits, [parity], stop 1.
// PARAMETERS
//   WIDTH      4  data bits per frame (>=2); bit counter is $clog2(WIDTH) bits
//   PARITY_EN  1  1: parity bit present between data and stop; 0: no parity bit
//   ODD        0  0: even parity (par bit == ^data); 1: odd parity (par bit == ~^data)
// PORTS
//   clk         in   1      system clock, all logic on rising edge
//   rst         in   1      synchronous reset, active-high
//   bit_en      in   1      bit-rate strobe; si is sampled only on edges where bit_en=1
//   si          in   1      serial input line
//   po          out  WIDTH  received word (holding register)
//   po_valid    out  1      po holds an unconsumed word
//   po_ready    in   1      consumer accepts po on an edge where po_valid & po_ready
//   sh_en       out  1      combinational: bit_en & (state==DATA); shifter step strobe
//   busy        out  1      state != IDLE
//   parity_err  out  1      1-cycle pulse: parity mismatch, frame discarded
//   frame_err   out  1      1-cycle pulse: stop bit sampled 0, frame discarded
//   overrun     out  1      1-cycle pulse: completed frame dropped, holding reg full
// BEHAVIOUR
//   Reset (rst=1 at an edge):
//     state=IDLE, cnt=0, shreg=0, po=0, po_valid=0, all pulses 0.
//     Overrides everything; a frame in progress is abandoned with no output and no error.
//   FSM: IDLE, DATA, PAR, STOP, WAIT_IDLE.
//     State changes only on edges with bit_en=1.
//     When bit_en=0, state, cnt and shreg hold, and si is ignored.
//   IDLE:      bit_en & si==0 -> DATA, cnt=0.
//   DATA:      bit_en -> shreg <= {si, shreg[WIDTH-1:1]}, cnt++.
//              On cnt==WIDTH-1: go to PAR if PARITY_EN, else STOP; cnt=0.
//   PAR:       bit_en -> capture si as parity bit -> STOP.
//   STOP:      bit_en, si==1, parity ok -> deliver word -> IDLE.
//              bit_en, si==1, parity bad -> parity_err=1 -> IDLE.
//              bit_en, si==0 -> frame_err=1 -> WAIT_IDLE (parity not reported).
//   WAIT_IDLE: bit_en & si==1 -> IDLE.
//              A held-low line never starts a new frame.
//   Deliver:
//     - po_valid=0, or po_ready=1 on the same edge: po <= shreg, po_valid=1.
//     - po_valid=1 and po_ready=0: word dropped, overrun=1, po unchanged.
//   Handshake:
//     - po_valid & po_ready and no delivery on that edge -> po_valid=0.
//     - po keeps its last value after consumption.
//     - po_valid never drops without po_ready.
//   Latency:
//     - po_valid rises on the edge that samples the stop bit.
//     - Start to valid = WIDTH+2+PARITY_EN strobes.
//     - Back-to-back frames are allowed: a start bit may be sampled on the strobe right after stop.
//   Pulses are registered and last exactly one clk, independent of the bit_en rate.
// TESTING
//   1 Reset, bit_en=1 every clk, WIDTH=4, even parity.
//     si=0,0,1,0,1,0,1 (start, data 0xA LSB-first, par 0, stop).
//     -> po=4'hA, po_valid=1 at 7th strobe edge; held until po_ready=1, then po_valid=0 next edge.
//   2 Same frame with parity bit 1.
//     -> parity_err pulses 1 clk, po_valid stays 0, busy=0 after stop.
//   3 Frame 0x5 with stop bit 0, then si held 0 for 5 strobes.
//     -> frame_err 1 clk, busy stays 1 (WAIT_IDLE), no new frame.
//     si=1 then frame 0x3 -> po=4'h3.
//   4 po_ready=0, frames 0x3 then 0x5 back-to-back.
//     -> po=3, overrun pulse at 2nd stop.
//     Repeat with po_ready=1 on 2nd stop edge -> po=5, po_valid stays 1, no overrun.
//   5 bit_en every 4th clk, si toggled randomly on non-strobe clks, frame 0xC.
//     -> po=4'hC, no errors; sh_en high only on strobe clks in DATA.
//   6 rst=1 for 1 clk after 2 data bits.
//     -> po_valid=0, busy=0, no pulses; next frame 0x6 received as po=4'h6.

Source files
------------

// File: rtl/s2p_frame_ctrl.sv
// Receive-side frame sequencer: start-bit detect, LSB-first data shift, optional
// parity and stop checks, and a 1-entry output holding register with valid/ready.
module s2p_frame_ctrl #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1,
  parameter int ODD       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             si,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             sh_en,
  output logic             busy,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DATA      = 3'd1,
    PAR       = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_po;
  logic             r_valid;
  logic             r_par;
  logic             r_perr;
  logic             r_ferr;
  logic             r_ovr;

  logic w_exp_par;
  logic w_par_ok;
  logic w_deliver;

  // Even parity expects par == ^data; odd parity expects the inverse.
  assign w_exp_par = (^r_shreg) ^ (ODD != 0);
  assign w_par_ok  = (PARITY_EN == 0) || (r_par == w_exp_par);
  assign w_deliver = bit_en && (r_state == STOP) && si && w_par_ok;

  // Output handshake: po is transferred on any edge where po_valid & po_ready;
  // po_valid only falls on such an edge, and po keeps its value afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_po    <= '0;
      r_valid <= 1'b0;
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;

      if (w_deliver) begin
        if (!r_valid || po_ready) begin
          r_po    <= r_shreg;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && po_ready) begin
        r_valid <= 1'b0;
      end

      if (bit_en) begin
        case (r_state)
          IDLE: begin
            if (!si) begin
              r_state <= DATA;
              r_cnt   <= '0;
            end
          end
          DATA: begin
            r_shreg <= {si, r_shreg[WIDTH-1:1]};
            if (r_cnt == LAST) begin
              r_cnt   <= '0;
              r_state <= (PARITY_EN != 0) ? PAR : STOP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          PAR: begin
            r_par   <= si;
            r_state <= STOP;
          end
          STOP: begin
            // A bad stop bit takes precedence; parity is not reported then.
            if (si) begin
              r_perr  <= !w_par_ok;
              r_state <= IDLE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            if (si) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign po         = r_po;
  assign po_valid   = r_valid;
  assign sh_en      = bit_en && (r_state == DATA);
  assign busy       = (r_state != IDLE);
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Directed bench for s2p_frame_ctrl (WIDTH=4, even parity) with hand-computed expectations.
module tb_s2p_frame_ctrl;

  logic       clk;
  logic       rst;
  logic       bit_en;
  logic       si;
  logic [3:0] po;
  logic       po_valid;
  logic       po_ready;
  logic       sh_en;
  logic       busy;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  int n_vec;
  int n_err;
  int gap;

  s2p_frame_ctrl #(.WIDTH(4), .PARITY_EN(1), .ODD(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .si         (si),
    .po         (po),
    .po_valid   (po_valid),
    .po_ready   (po_ready),
    .sh_en      (sh_en),
    .busy       (busy),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One clock with no strobe.
  task automatic idle_clk();
    bit_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Preceded by gap-1 non-strobe clocks carrying random si, then one strobe clock.
  task automatic strobe(input logic b, input logic exp_sh);
    for (int i = 1; i < gap; i++) begin
      bit_en = 1'b0;
      si     = 1'($urandom_range(0, 1));
      #1;
      check("sh_en_gap", {31'd0, sh_en}, 32'd0);
      @(posedge clk);
      #1;
    end
    si     = b;
    bit_en = 1'b1;
    #1;
    check("sh_en", {31'd0, sh_en}, {31'd0, exp_sh});
    @(posedge clk);
    #1;
    bit_en = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] d, input logic par, input logic stop,
                            input logic rdy_on_stop);
    strobe(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) strobe(d[i], 1'b1);
    strobe(par, 1'b0);
    po_ready = rdy_on_stop;
    strobe(stop, 1'b0);
    po_ready = 1'b0;
  endtask

  task automatic consume();
    po_ready = 1'b1;
    idle_clk();
    po_ready = 1'b0;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    gap      = 1;
    rst      = 1'b1;
    bit_en   = 1'b0;
    si       = 1'b1;
    po_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {26'd0, po, po_valid, busy, parity_err, frame_err, overrun, sh_en}, 32'd0);
    rst = 1'b0;
    idle_clk();

    // 1: good frame 0xA, even parity 0; valid appears on the 7th strobe
    strobe(1'b0, 1'b0);
    strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b1);
    strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b1);
    strobe(1'b0, 1'b0);
    check("t1_valid_before_stop", {31'd0, po_valid}, 32'd0);
    check("t1_busy_before_stop", {31'd0, busy}, 32'd1);
    strobe(1'b1, 1'b0);
    check("t1_po", {28'd0, po}, 32'hA);
    check("t1_valid", {31'd0, po_valid}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd0);
    repeat (3) idle_clk();
    check("t1_valid_held", {31'd0, po_valid}, 32'd1);
    consume();
    check("t1_valid_consumed", {31'd0, po_valid}, 32'd0);
    check("t1_po_kept", {28'd0, po}, 32'hA);

    // 2: same frame with wrong parity bit
    send_frame(4'hA, 1'b1, 1'b1, 1'b0);
    check("t2_perr", {29'd0, parity_err, frame_err, overrun}, 32'b100);
    check("t2_valid", {31'd0, po_valid}, 32'd0);
    check("t2_busy", {31'd0, busy}, 32'd0);
    idle_clk();
    check("t2_perr_1clk", {31'd0, parity_err}, 32'd0);

    // 3: bad stop bit, held-low line, then recovery
    send_frame(4'h5, 1'b0, 1'b0, 1'b0);
    check("t3_ferr", {29'd0, parity_err, frame_err, overrun}, 32'b010);
    check("t3_busy", {31'd0, busy}, 32'd1);
    repeat (5) strobe(1'b0, 1'b0);
    check("t3_wait_busy", {31'd0, busy}, 32'd1);
    check("t3_wait_flags", {29'd0, po_valid, frame_err, parity_err}, 32'd0);
    strobe(1'b1, 1'b0);
    check("t3_back_idle", {31'd0, busy}, 32'd0);
    send_frame(4'h3, 1'b0, 1'b1, 1'b0);
    check("t3_po", {28'd0, po}, 32'h3);
    check("t3_valid", {31'd0, po_valid}, 32'd1);
    consume();

    // 4: overrun with holding register full, then replace-on-ready
    send_frame(4'h3, 1'b0, 1'b1, 1'b0);
    check("t4a_po1", {28'd0, po}, 32'h3);
    send_frame(4'h5, 1'b0, 1'b1, 1'b0);
    check("t4a_overrun", {31'd0, overrun}, 32'd1);
    check("t4a_po_kept", {27'd0, po, po_valid}, {27'd0, 4'h3, 1'b1});
    idle_clk();
    check("t4a_overrun_1clk", {31'd0, overrun}, 32'd0);
    consume();
    send_frame(4'h3, 1'b0, 1'b1, 1'b0);
    send_frame(4'h5, 1'b0, 1'b1, 1'b1);
    check("t4b_po", {27'd0, po, po_valid}, {27'd0, 4'h5, 1'b1});
    check("t4b_no_overrun", {31'd0, overrun}, 32'd0);
    consume();
    check("t4b_consumed", {31'd0, po_valid}, 32'd0);

    // 5: slow strobe, noise on non-strobe clocks; 0xC has even parity 0
    gap = 4;
    send_frame(4'hC, 1'b0, 1'b1, 1'b0);
    check("t5_po", {27'd0, po, po_valid}, {27'd0, 4'hC, 1'b1});
    check("t5_no_err", {29'd0, parity_err, frame_err, overrun}, 32'd0);
    gap = 1;
    si  = 1'b1;
    idle_clk();

    // 6: reset mid-frame clears the pending word and abandons the frame
    strobe(1'b0, 1'b0);
    strobe(1'b0, 1'b1);
    strobe(1'b1, 1'b1);
    rst = 1'b1;
    si  = 1'b1;
    idle_clk();
    rst = 1'b0;
    check("t6_after_rst", {26'd0, po, po_valid, busy, parity_err, frame_err, overrun, sh_en}, 32'd0);
    idle_clk();
    check("t6_no_pulses", {29'd0, parity_err, frame_err, overrun}, 32'd0);
    send_frame(4'h6, 1'b0, 1'b1, 1'b0);
    check("t6_po", {27'd0, po, po_valid}, {27'd0, 4'h6, 1'b1});
    check("t6_no_err", {29'd0, parity_err, frame_err, overrun}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
